// File: rtl/params_noc.sv
// Shared NoC types: flit labels, head layout and VC-tagged flit bundle.
package params_noc;

  localparam int vc_Num             = 2;
  localparam int VC_Size            = $clog2(vc_Num);
  localparam int flit_Size          = 24;
  localparam int x_Des              = 4;
  localparam int y_Des              = 4;
  localparam int header_Payloadsize = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_Data_Label;

  typedef struct packed {
    logic [x_Des-1:0]              x_Dest;
    logic [y_Des-1:0]              y_Dest;
    logic [header_Payloadsize-1:0] header_Payload;
  } packet_Header;

  typedef union packed {
    packet_Header         head_Data;
    logic [flit_Size-1:0] flit;
  } flit_Data;

  typedef struct packed {
    flit_Data_Label       flit_DataLabel;
    logic [VC_Size-1:0]   vc_Id;
    flit_Data             data;
  } flit_Data_withvc;

endpackage

// File: rtl/vc_credit_counter.sv
// Downstream buffer credit count for one VC; send and return in the
// same cycle cancel out.
module vc_credit_counter #(
  parameter int BUF_DEPTH = 4,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic has_credit_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc_i, dec_i})
      2'b10: if (cnt_q != CW'(BUF_DEPTH)) cnt_d = cnt_q + 1'b1;
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= CW'(BUF_DEPTH);
    else     cnt_q <= cnt_d;
  end

  assign has_credit_o = (cnt_q != '0);

endmodule

// File: rtl/noc_flit_injector.sv
// Packetises core descriptors and body words into VC-tagged flits for
// the router LOCAL port, gated by per-VC downstream credits.
module noc_flit_injector
  import params_noc::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int MAX_BODY  = 14,
  localparam int LEN_W = $clog2(MAX_BODY + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 pkt_valid_i,
  output logic                                 pkt_ready_o,
  input  logic [x_Des-1:0]                     pkt_x_dest_i,
  input  logic [y_Des-1:0]                     pkt_y_dest_i,
  input  logic [header_Payloadsize-1:0]        pkt_payload_i,
  input  logic [LEN_W-1:0]                     pkt_body_len_i,
  input  logic                                 body_valid_i,
  output logic                                 body_ready_o,
  input  logic [flit_Size-1:0]                 body_data_i,
  output logic [$bits(flit_Data_withvc)-1:0]   flit_o,
  output logic                                 flit_valid_o,
  input  logic [vc_Num-1:0]                    credit_i,
  output logic                                 busy_o
);

  typedef enum logic {ST_IDLE, ST_BODY} state_e;

  state_e             state_q, state_d;
  logic [VC_Size-1:0] rr_q, rr_d;
  logic [VC_Size-1:0] cur_vc_q, cur_vc_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  flit_Data_withvc    flit_q, flit_d;
  logic               fvld_q, fvld_d;

  logic [vc_Num-1:0]  has_cred;
  logic [vc_Num-1:0]  dec;
  logic [VC_Size-1:0] chosen;
  logic [VC_Size-1:0] idx;
  logic               found;
  logic [LEN_W-1:0]   len_cl;
  logic               pkt_hs;
  logic               body_hs;

  // Round-robin search starting at rr_q for the first VC holding credit
  always_comb begin
    found  = 1'b0;
    chosen = rr_q;
    idx    = '0;
    for (int i = 0; i < vc_Num; i++) begin
      idx = VC_Size'((int'(rr_q) + i) % vc_Num);
      if (!found && has_cred[idx]) begin
        chosen = idx;
        found  = 1'b1;
      end
    end
  end

  assign len_cl = (pkt_body_len_i > LEN_W'(MAX_BODY))
                ? LEN_W'(MAX_BODY) : pkt_body_len_i;

  assign pkt_hs = !rst && (state_q == ST_IDLE)
                && pkt_valid_i && found;
  assign body_hs = !rst && (state_q == ST_BODY)
                 && body_valid_i && has_cred[cur_vc_q];

  assign pkt_ready_o  = pkt_hs;
  assign body_ready_o = body_hs;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cur_vc_d = cur_vc_q;
    remain_d = remain_q;
    flit_d   = flit_q;
    fvld_d   = 1'b0;
    unique case (1'b1)
      pkt_hs: begin
        flit_d.flit_DataLabel = (len_cl == '0) ? HEADTAIL : HEAD;
        flit_d.vc_Id          = chosen;
        flit_d.data.head_Data.x_Dest         = pkt_x_dest_i;
        flit_d.data.head_Data.y_Dest         = pkt_y_dest_i;
        flit_d.data.head_Data.header_Payload = pkt_payload_i;
        fvld_d   = 1'b1;
        cur_vc_d = chosen;
        remain_d = len_cl;
        rr_d     = VC_Size'((int'(chosen) + 1) % vc_Num);
        state_d  = (len_cl != '0) ? ST_BODY : ST_IDLE;
      end
      body_hs: begin
        flit_d.flit_DataLabel = (remain_q == LEN_W'(1)) ? TAIL : BODY;
        flit_d.vc_Id          = cur_vc_q;
        flit_d.data.flit      = body_data_i;
        fvld_d   = 1'b1;
        remain_d = remain_q - 1'b1;
        if (remain_q == LEN_W'(1)) state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      cur_vc_q <= '0;
      remain_q <= '0;
      flit_q   <= '0;
      fvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cur_vc_q <= cur_vc_d;
      remain_q <= remain_d;
      flit_q   <= flit_d;
      fvld_q   <= fvld_d;
    end
  end

  for (genvar v = 0; v < vc_Num; v++) begin : g_vc
    assign dec[v] = (pkt_hs && chosen == VC_Size'(v))
                  || (body_hs && cur_vc_q == VC_Size'(v));

    vc_credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_cred (
      .clk          (clk),
      .rst          (rst),
      .inc_i        (credit_i[v]),
      .dec_i        (dec[v]),
      .has_credit_o (has_cred[v])
    );
  end

  assign flit_o       = flit_q;
  assign flit_valid_o = fvld_q;
  assign busy_o       = (state_q == ST_BODY);

endmodule

// File: tb/tb_noc_flit_injector.sv
// Directed bench for noc_flit_injector with a credit/VC reference model
// and an expected-flit queue.
module tb_noc_flit_injector;
  import params_noc::*;

  localparam int BUF_DEPTH = 4;
  localparam int MAX_BODY  = 14;
  localparam int LEN_W     = 4;
  localparam int FW        = $bits(flit_Data_withvc);

  logic              clk = 1'b0;
  logic              rst;
  logic              pkt_valid_i;
  logic              pkt_ready_o;
  logic [3:0]        pkt_x_dest_i;
  logic [3:0]        pkt_y_dest_i;
  logic [15:0]       pkt_payload_i;
  logic [LEN_W-1:0]  pkt_body_len_i;
  logic              body_valid_i;
  logic              body_ready_o;
  logic [23:0]       body_data_i;
  logic [FW-1:0]     flit_o;
  logic              flit_valid_o;
  logic [1:0]        credit_i;
  logic              busy_o;

  noc_flit_injector #(.BUF_DEPTH(BUF_DEPTH), .MAX_BODY(MAX_BODY)) dut (
    .clk            (clk),
    .rst            (rst),
    .pkt_valid_i    (pkt_valid_i),
    .pkt_ready_o    (pkt_ready_o),
    .pkt_x_dest_i   (pkt_x_dest_i),
    .pkt_y_dest_i   (pkt_y_dest_i),
    .pkt_payload_i  (pkt_payload_i),
    .pkt_body_len_i (pkt_body_len_i),
    .body_valid_i   (body_valid_i),
    .body_ready_o   (body_ready_o),
    .body_data_i    (body_data_i),
    .flit_o         (flit_o),
    .flit_valid_o   (flit_valid_o),
    .credit_i       (credit_i),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int ntot  = 0;
  int npass = 0;
  int nfail = 0;

  int m_cred [2];
  int m_rr, m_vc, m_rem;
  bit m_busy;

  flit_Data_withvc q [$];

  logic [3:0]  px, py;
  logic [15:0] pp;
  int          plen;
  logic [23:0] bdata;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cred[0] = BUF_DEPTH;
    m_cred[1] = BUF_DEPTH;
    m_rr = 0; m_vc = 0; m_rem = 0; m_busy = 0;
    q.delete();
  endtask

  task automatic step(input bit pv, input bit bv, input logic [1:0] cr);
    bit hp, hb;
    int ch, k;
    flit_Data_withvc e;
    pkt_valid_i    = pv;
    pkt_x_dest_i   = px;
    pkt_y_dest_i   = py;
    pkt_payload_i  = pp;
    pkt_body_len_i = LEN_W'(plen);
    body_valid_i   = bv;
    body_data_i    = bdata;
    credit_i       = cr;
    @(negedge clk);
    ch = -1;
    for (int i = 0; i < 2; i++) begin
      k = (m_rr + i) % 2;
      if (ch < 0 && m_cred[k] > 0) ch = k;
    end
    hp = pv && !m_busy && ch >= 0;
    hb = bv && m_busy && m_cred[m_vc] > 0;
    chk("pkt_ready", pkt_ready_o, hp);
    chk("body_ready", body_ready_o, hb);
    e = '0;
    if (hp) begin
      e.flit_DataLabel = (plen == 0) ? HEADTAIL : HEAD;
      e.vc_Id = ch[0];
      e.data.head_Data.x_Dest = px;
      e.data.head_Data.y_Dest = py;
      e.data.head_Data.header_Payload = pp;
      q.push_back(e);
      m_cred[ch]--;
      m_vc  = ch;
      m_rem = (plen > MAX_BODY) ? MAX_BODY : plen;
      m_rr  = (ch + 1) % 2;
      m_busy = (m_rem > 0);
    end
    if (hb) begin
      e.flit_DataLabel = (m_rem == 1) ? TAIL : BODY;
      e.vc_Id = m_vc[0];
      e.data.flit = bdata;
      q.push_back(e);
      m_cred[m_vc]--;
      m_rem--;
      if (m_rem == 0) m_busy = 0;
    end
    for (int v = 0; v < 2; v++)
      if (cr[v] && m_cred[v] < BUF_DEPTH) m_cred[v]++;
    @(posedge clk);
    #1;
    pkt_valid_i  = 1'b0;
    body_valid_i = 1'b0;
    credit_i     = '0;
    if (hp || hb) begin
      chk("flit_valid", flit_valid_o, 1'b1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("flit", flit_o, e);
      end
    end else begin
      chk("flit_idle", flit_valid_o, 1'b0);
    end
    chk("busy", busy_o, m_busy);
    if (hb) bdata++;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_flit_valid", flit_valid_o, 1'b0);
    chk("rst_flit", flit_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_pkt_ready", pkt_ready_o, 1'b0);
    chk("rst_body_ready", body_ready_o, 1'b0);
  endtask

  task automatic desc(input logic [3:0] x, input logic [3:0] y,
                      input logic [15:0] p, input int len);
    px = x; py = y; pp = p; plen = len;
    step(1, 0, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    pkt_valid_i = 1'b1;
    body_valid_i = 1'b1;
    pkt_x_dest_i = '0; pkt_y_dest_i = '0; pkt_payload_i = '0;
    pkt_body_len_i = '0; body_data_i = '0; credit_i = '0;
    px = '0; py = '0; pp = '0; plen = 0; bdata = 24'h000001;
    model_reset();
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt_valid_i = 1'b0;
    body_valid_i = 1'b0;

    // single HEADTAIL on vc0
    desc(4'd3, 4'd5, 16'hBEEF, 0);

    // 3-body packet: goes to vc1 by round robin
    desc(4'd1, 4'd2, 16'h1234, 3);
    repeat (3) step(0, 1, 2'b00);
    step(0, 0, 2'b11);
    repeat (3) step(0, 0, 2'b10);

    // credit stall on vc0 with 6 bodies
    bdata = 24'h000010;
    desc(4'd7, 4'd1, 16'hA5A5, 6);
    repeat (3) step(0, 1, 2'b00);
    step(0, 1, 2'b00);
    step(0, 1, 2'b01);
    step(0, 1, 2'b00);
    step(0, 1, 2'b00);
    step(0, 1, 2'b01);
    step(0, 1, 2'b01);
    step(0, 1, 2'b00);

    // round robin with vc0 exhausted, then vc0/vc1 alternation
    desc(4'd2, 4'd2, 16'h0001, 0);
    desc(4'd2, 4'd3, 16'h0002, 0);
    repeat (4) step(0, 0, 2'b01);
    desc(4'd4, 4'd4, 16'h0003, 0);
    desc(4'd5, 4'd5, 16'h0004, 0);

    // reset mid-BODY
    desc(4'd9, 4'd8, 16'hC0DE, 5);
    repeat (2) step(0, 1, 2'b00);
    #2;
    rst = 1'b1;
    pkt_valid_i = 1'b1;
    body_valid_i = 1'b1;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt_valid_i = 1'b0;
    body_valid_i = 1'b0;
    model_reset();
    bdata = 24'h000100;
    desc(4'd6, 4'd6, 16'hFACE, 3);
    repeat (3) step(0, 1, 2'b00);

    // oversized length clamps to MAX_BODY; credits recycled each cycle
    bdata = 24'h000200;
    desc(4'd15, 4'd0, 16'hFFFF, 15);
    repeat (MAX_BODY) step(0, 1, 2'b10);
    step(0, 1, 2'b00);

    chk("scoreboard_empty", q.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
